clock_source: RTL and testbench
===============================

// Module: clock_source
// PURPOSE
//  Drives the clock module's inputs: astable pulse (apulse), debounced single-step pulse (mpulse)
//  and debounced mode select (select). Sits between board I/O (step button, mode switch) and clock.
//  Astable rate is software/bench programmable via a load port.
//  Replaces the testbench-only #2 toggling and raw button wiring with synthesizable logic.
// PARAMETERS
//  DIV_WIDTH        16  width of half-period divider register
//  DEFAULT_DIV      2   half-period (clk cycles) loaded at reset
//  DEBOUNCE_CYCLES  4   consecutive stable cycles required to accept an input change
//  MPULSE_LEN       3   mpulse high time in clk cycles per accepted press
//  REPEAT_DELAY     64  cycles held before auto-repeat starts (STEP_REPEAT_EN only)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  div_load   in   1          load div_value into divider this cycle
//  div_value  in   DIV_WIDTH  new half-period; 0 treated as 1
//  btn_step   in   1          raw, async, bouncing step button (1 = pressed)
//  sw_mode    in   1          raw, async mode switch (1 = astable, 0 = manual)
//  apulse     out  1          astable square wave to clock
//  mpulse     out  1          manual pulse to clock
//  select     out  1          debounced sw_mode to clock
// BEHAVIOUR
//  Reset (rst=1 at posedge): apulse=0, mpulse=0, select=1, div_reg=DEFAULT_DIV, counters=0,
//   step FSM=IDLE, sync flops and debounced levels=0 (select's debounced level=1). Mid-operation
//   reset aborts any pulse in the same edge.
//  Input path: each raw input -> 2-flop synchronizer -> debouncer. Debouncer count increments
//   each cycle sync!=db, clears when equal; at count==DEBOUNCE_CYCLES-1 with mismatch, db<=sync,
//   count<=0. Raw change to db change: exactly DEBOUNCE_CYCLES+2 cycles. Glitch shorter: ignored.
//  Astable: half counter increments each cycle; when count==max(div_reg,1)-1, apulse toggles and
//   count<=0. Period = 2*max(div_reg,1) cycles. div_load: div_reg<=div_value, count<=0, apulse
//   holds level; next toggle after the new half-period. Load and terminal count same cycle: load wins.
//  apulse runs regardless of select; clock does the muxing.
//  Step FSM (on debounced btn level b):
//   IDLE  --b rising--> PULSE (mpulse=1 from next cycle)
//   PULSE --MPULSE_LEN cycles--> RELEASE (mpulse=0)
//   RELEASE --b==0--> IDLE
//  Exactly one mpulse per press; holding produces no further pulses. Press during PULSE/RELEASE
//   ignored. mpulse latency: rising debounced edge +1 cycle. select change mid-pulse: pulse completes.
// CONFIGURATION
//  STEP_REPEAT_EN defined: in RELEASE with b==1 for REPEAT_DELAY cycles, FSM -> PULSE again, then
//   repeats every MPULSE_LEN+REPEAT_DELAY cycles while held; release returns to IDLE after any
//   in-progress pulse. Not defined: repeat counter absent, behaviour exactly as above.
// STRUCTURE
//  Shared header clock_pkg.vh: step FSM state encodings (IDLE/PULSE/RELEASE), reset defaults,
//   select reset level. Sub-module clock_debounce (sync + debounce, parameter DEBOUNCE_CYCLES,
//   RESET_VAL), instantiated twice (btn_step, sw_mode). Divider and step FSM in top.
// TESTING  (DEFAULT_DIV=2, DEBOUNCE_CYCLES=4, MPULSE_LEN=3, REPEAT_DELAY=8)
//  1 rst 2 cycles, release -> apulse=0, mpulse=0, select=1; apulse toggles every 2 cycles, period 4
//  2 div_load=1, div_value=5 one cycle -> next toggle 5 cycles later, period 10; div_value=0 -> period 2
//  3 btn_step rises, held 20 cycles -> mpulse high exactly 3 cycles, starts 7 cycles after raw rise; once only
//  4 btn_step pulses 1-2-1-3 cycles (bounce) then low -> no mpulse; sw_mode 0 for 3 cycles -> select stays 1
//  5 sw_mode->0 held -> select=0 after 6 cycles; rst asserted during mpulse -> mpulse=0 next edge
//  6 STEP_REPEAT_EN, btn held 40 cycles -> first pulse then repeats every 11 cycles; off -> single pulse

Source files
------------

// File: rtl/clock_source_pkg.sv
// -----------------------------------------------------------------------------
// clock_source_pkg
//  Shared definitions for the clock_source block: step FSM state encoding,
//  reset levels of the registered outputs and the debounced levels, and a
//  helper that sizes a counter able to hold the values 0..n-1.
//  No ports (package).
// -----------------------------------------------------------------------------
package clock_source_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_RELEASE = 2'd2
   } step_state_t;

   localparam logic APULSE_RST = 1'b0;
   localparam logic MPULSE_RST = 1'b0;
   localparam logic BTN_RST    = 1'b0;
   // Astable mode is the safe power-up choice, so select comes out of reset high.
   localparam logic SELECT_RST = 1'b1;

   // Bits needed to count 0..n-1 (never less than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_source_debounce.sv
// -----------------------------------------------------------------------------
// clock_source_debounce
//  Two-flop synchronizer followed by a stability counter. The debounced level
//  follows the synchronized input only after it has differed from the current
//  level for DEBOUNCE_CYCLES consecutive cycles; a raw change therefore shows
//  up on db_o DEBOUNCE_CYCLES+2 cycles later and shorter glitches are dropped.
// Ports
//  clk_i  in   system clock
//  rst_i  in   synchronous active-high reset
//  raw_i  in   raw asynchronous input
//  db_o   out  debounced level (RESET_VAL after reset)
// -----------------------------------------------------------------------------
module clock_source_debounce
   import clock_source_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic db_o
);

   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;

   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         db_q    <= RESET_VAL;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/clock_source.sv
// -----------------------------------------------------------------------------
// clock_source
//  Generates the inputs of the clock module: a programmable astable square
//  wave, a debounced single-step pulse and a debounced mode select.
//  Optional feature: define STEP_REPEAT_EN to auto-repeat the step pulse while
//  the button stays held (adds the REPEAT_DELAY parameter and repeat counter).
// Ports
//  clk_i        in   system clock
//  rst_i        in   synchronous active-high reset
//  div_load_i   in   load div_value_i into the half-period register
//  div_value_i  in   new half-period in clk cycles (0 behaves as 1)
//  btn_step_i   in   raw step button, 1 = pressed
//  sw_mode_i    in   raw mode switch, 1 = astable, 0 = manual
//  apulse_o     out  astable square wave, period 2*max(div,1)
//  mpulse_o     out  MPULSE_LEN-cycle pulse per accepted press
//  select_o     out  debounced mode switch
//
// Step FSM
//  state      | meaning
//  ST_IDLE    | waiting for a debounced press
//  ST_PULSE   | mpulse high, counting MPULSE_LEN cycles
//  ST_RELEASE | pulse done, waiting for the button to be let go
//             | (with STEP_REPEAT_EN: also timing the auto-repeat delay)
// -----------------------------------------------------------------------------
module clock_source
   import clock_source_pkg::*;
#(
   parameter int unsigned DIV_WIDTH       = 16,
   parameter int unsigned DEFAULT_DIV     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned MPULSE_LEN      = 3
`ifdef STEP_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY    = 64
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 div_load_i,
   input  logic [DIV_WIDTH-1:0] div_value_i,
   input  logic                 btn_step_i,
   input  logic                 sw_mode_i,
   output logic                 apulse_o,
   output logic                 mpulse_o,
   output logic                 select_o
);

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
   localparam int unsigned          PW         = cnt_width(MPULSE_LEN);
   localparam logic [PW-1:0]        PULSE_LAST = PW'(MPULSE_LEN - 1);
   localparam logic [PW-1:0]        PULSE_ONE  = PW'(1);
`ifdef STEP_REPEAT_EN
   localparam int unsigned          RW         = cnt_width(REPEAT_DELAY);
   localparam logic [RW-1:0]        REP_LAST   = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]        REP_ONE    = RW'(1);
`endif

   logic btn_db;
   logic sel_db;

   clock_source_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (BTN_RST)
   ) u_db_btn (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (btn_step_i),
      .db_o  (btn_db)
   );

   clock_source_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (SELECT_RST)
   ) u_db_sel (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (sw_mode_i),
      .db_o  (sel_db)
   );

   // ---------------------------------------------------------------- astable
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] half_q, half_d;
   logic [DIV_WIDTH-1:0] half_last;
   logic                 apulse_q, apulse_d;

   always_comb begin
      // A zero divider runs at the fastest rate rather than stalling.
      half_last = (div_q == '0) ? '0 : (div_q - DIV_ONE);
      div_d     = div_q;
      half_d    = half_q + DIV_ONE;
      apulse_d  = apulse_q;
      if (div_load_i) begin
         // Load wins over a terminal count in the same cycle; level is held.
         div_d  = div_value_i;
         half_d = '0;
      end else if (half_q == half_last) begin
         half_d   = '0;
         apulse_d = ~apulse_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q    <= DIV_RST;
         half_q   <= '0;
         apulse_q <= APULSE_RST;
      end else begin
         div_q    <= div_d;
         half_q   <= half_d;
         apulse_q <= apulse_d;
      end
   end

   // -------------------------------------------------------------- step FSM
   step_state_t   state_q;
   logic [PW-1:0] pcnt_q;
   logic          mpulse_q;
`ifdef STEP_REPEAT_EN
   logic [RW-1:0] rep_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         pcnt_q   <= '0;
         mpulse_q <= MPULSE_RST;
`ifdef STEP_REPEAT_EN
         rep_q    <= '0;
`endif
      end else begin
         case (state_q)
            // IDLE is only entered with the button released, so a high level
            // here is always a fresh press.
            ST_IDLE: begin
               if (btn_db) begin
                  state_q  <= ST_PULSE;
                  mpulse_q <= 1'b1;
                  pcnt_q   <= '0;
               end
            end
            ST_PULSE: begin
               if (pcnt_q == PULSE_LAST) begin
                  state_q  <= ST_RELEASE;
                  mpulse_q <= 1'b0;
                  pcnt_q   <= '0;
`ifdef STEP_REPEAT_EN
                  rep_q    <= '0;
`endif
               end else begin
                  pcnt_q <= pcnt_q + PULSE_ONE;
               end
            end
            ST_RELEASE: begin
               if (!btn_db) begin
                  state_q <= ST_IDLE;
               end
`ifdef STEP_REPEAT_EN
               else if (rep_q == REP_LAST) begin
                  state_q  <= ST_PULSE;
                  mpulse_q <= 1'b1;
                  pcnt_q   <= '0;
               end else begin
                  rep_q <= rep_q + REP_ONE;
               end
`endif
            end
            default: begin
               state_q  <= ST_IDLE;
               mpulse_q <= 1'b0;
            end
         endcase
      end
   end

   assign apulse_o = apulse_q;
   assign mpulse_o = mpulse_q;
   assign select_o = sel_db;

endmodule

// File: tb/tb_clock_source.sv
// -----------------------------------------------------------------------------
// tb_clock_source
//  Self-checking bench for clock_source (DEFAULT_DIV=2, DEBOUNCE_CYCLES=4,
//  MPULSE_LEN=3, REPEAT_DELAY=8). Inputs change 2 ns after a rising edge; a
//  recorder logs output edges on the falling edge with the edge count.
// -----------------------------------------------------------------------------
module tb_clock_source;

   logic        clk = 1'b0;
   logic        rst;
   logic        div_load;
   logic [15:0] div_value;
   logic        btn_step;
   logic        sw_mode;
   logic        apulse, mpulse, select;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int ap_obs[$];
   int mr_obs[$];
   int mf_obs[$];
   int sel_obs[$];
   int exp_q[$];
   int exp2_q[$];

   logic ap_prev  = 1'b0;
   logic mp_prev  = 1'b0;
   logic sel_prev = 1'b1;

   clock_source #(
      .DIV_WIDTH       (16),
      .DEFAULT_DIV     (2),
      .DEBOUNCE_CYCLES (4),
      .MPULSE_LEN      (3)
`ifdef STEP_REPEAT_EN
      ,
      .REPEAT_DELAY    (8)
`endif
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .div_load_i  (div_load),
      .div_value_i (div_value),
      .btn_step_i  (btn_step),
      .sw_mode_i   (sw_mode),
      .apulse_o    (apulse),
      .mpulse_o    (mpulse),
      .select_o    (select)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (apulse !== ap_prev) ap_obs.push_back(cyc);
      if (mpulse === 1'b1 && mp_prev !== 1'b1) mr_obs.push_back(cyc);
      if (mpulse === 1'b0 && mp_prev === 1'b1) mf_obs.push_back(cyc);
      if (select !== sel_prev) sel_obs.push_back(cyc);
      ap_prev  = apulse;
      mp_prev  = mpulse;
      sel_prev = select;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic test_reset();
      int k, e, o;
      rst = 1'b1; div_load = 1'b0; div_value = '0; btn_step = 1'b0; sw_mode = 1'b1;
      tick(3);
      n_cmp++; if (apulse !== 1'b0) begin n_err++; $display("FAIL reset_apulse: got %b expected 0", apulse); end
      n_cmp++; if (mpulse !== 1'b0) begin n_err++; $display("FAIL reset_mpulse: got %b expected 0", mpulse); end
      n_cmp++; if (select !== 1'b1) begin n_err++; $display("FAIL reset_select: got %b expected 1", select); end
      ap_obs.delete();
      k = cyc;
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) exp_q.push_back(k + 2 * i);
      tick(9);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (ap_obs.size() == 0) begin
            n_err++; $display("FAIL reset_toggle: got no toggle expected toggle at cycle +%0d", e - k);
         end else begin
            o = ap_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL reset_toggle: got cycle +%0d expected +%0d", o - k, e - k); end
         end
      end
      n_cmp++; if (ap_obs.size() != 0) begin n_err++; $display("FAIL reset_toggle_extra: got %0d extra expected 0", ap_obs.size()); end
   endtask

   task automatic test_div_load();
      int k, e, o;
      // half-period 5
      ap_obs.delete();
      k = cyc;
      div_load = 1'b1; div_value = 16'd5;
      for (int i = 0; i < 4; i++) exp_q.push_back(k + 6 + 5 * i);
      tick(1);
      div_load = 1'b0;
      tick(21);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (ap_obs.size() == 0) begin
            n_err++; $display("FAIL div5_toggle: got no toggle expected toggle at cycle +%0d", e - k);
         end else begin
            o = ap_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL div5_toggle: got cycle +%0d expected +%0d", o - k, e - k); end
         end
      end
      n_cmp++; if (ap_obs.size() != 0) begin n_err++; $display("FAIL div5_extra: got %0d extra expected 0", ap_obs.size()); end
      // half-period 0 behaves as 1
      ap_obs.delete();
      k = cyc;
      div_load = 1'b1; div_value = 16'd0;
      for (int i = 0; i < 6; i++) exp_q.push_back(k + 2 + i);
      tick(1);
      div_load = 1'b0;
      tick(7);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (ap_obs.size() == 0) begin
            n_err++; $display("FAIL div0_toggle: got no toggle expected toggle at cycle +%0d", e - k);
         end else begin
            o = ap_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL div0_toggle: got cycle +%0d expected +%0d", o - k, e - k); end
         end
      end
      n_cmp++; if (ap_obs.size() != 0) begin n_err++; $display("FAIL div0_extra: got %0d extra expected 0", ap_obs.size()); end
      div_load = 1'b1; div_value = 16'd2;
      tick(1);
      div_load = 1'b0;
   endtask

   // Button held for h cycles; expected pulses come from the press timing:
   // first rise 7 cycles after the raw press, 3 cycles wide, and (with
   // auto-repeat) another every 11 cycles while the debounced level holds.
   task automatic test_hold(input int h);
      int k, e, o, r;
      mr_obs.delete(); mf_obs.delete();
      k = cyc;
      btn_step = 1'b1;
      r = k + 7;
      exp_q.push_back(r); exp2_q.push_back(r + 3);
`ifdef STEP_REPEAT_EN
      while (r + 11 <= k + h + 6) begin
         r = r + 11;
         exp_q.push_back(r); exp2_q.push_back(r + 3);
      end
`endif
      tick(h);
      btn_step = 1'b0;
      tick(20);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (mr_obs.size() == 0) begin
            n_err++; $display("FAIL hold%0d_rise: got no rise expected rise at cycle +%0d", h, e - k);
         end else begin
            o = mr_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL hold%0d_rise: got cycle +%0d expected +%0d", h, o - k, e - k); end
         end
      end
      while (exp2_q.size() > 0) begin
         e = exp2_q.pop_front();
         n_cmp++;
         if (mf_obs.size() == 0) begin
            n_err++; $display("FAIL hold%0d_fall: got no fall expected fall at cycle +%0d", h, e - k);
         end else begin
            o = mf_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL hold%0d_fall: got cycle +%0d expected +%0d", h, o - k, e - k); end
         end
      end
      n_cmp++; if (mr_obs.size() != 0) begin n_err++; $display("FAIL hold%0d_extra: got %0d extra pulses expected 0", h, mr_obs.size()); end
   endtask

   task automatic test_bounce();
      logic bpat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      mr_obs.delete();
      foreach (bpat[i]) begin
         btn_step = bpat[i];
         tick(1);
      end
      btn_step = 1'b0;
      tick(12);
      n_cmp++; if (mr_obs.size() != 0) begin n_err++; $display("FAIL bounce_mpulse: got %0d pulses expected 0", mr_obs.size()); end
      sel_obs.delete();
      sw_mode = 1'b0;
      tick(3);
      sw_mode = 1'b1;
      tick(10);
      n_cmp++; if (sel_obs.size() != 0) begin n_err++; $display("FAIL glitch_select_edges: got %0d expected 0", sel_obs.size()); end
      n_cmp++; if (select !== 1'b1) begin n_err++; $display("FAIL glitch_select: got %b expected 1", select); end
   endtask

   task automatic test_select();
      int k, e, o;
      for (int p = 0; p < 2; p++) begin
         sel_obs.delete();
         k = cyc;
         sw_mode = (p == 1);
         exp_q.push_back(k + 6);
         tick(8);
         e = exp_q.pop_front();
         n_cmp++;
         if (sel_obs.size() == 0) begin
            n_err++; $display("FAIL select_latency: got no change expected change at cycle +%0d", e - k);
         end else begin
            o = sel_obs.pop_front();
            if (o !== e) begin n_err++; $display("FAIL select_latency: got cycle +%0d expected +%0d", o - k, e - k); end
         end
         n_cmp++; if (select !== sw_mode) begin n_err++; $display("FAIL select_level: got %b expected %b", select, sw_mode); end
      end
   endtask

   task automatic test_select_mid_pulse();
      int k, o;
      mr_obs.delete(); mf_obs.delete(); sel_obs.delete();
      k = cyc;
      btn_step = 1'b1;
      tick(2);
      sw_mode = 1'b0;
      tick(8);
      btn_step = 1'b0;
      tick(12);
      n_cmp++;
      if (sel_obs.size() == 0) begin n_err++; $display("FAIL midsel_select: got no change expected change at cycle +8"); end
      else begin o = sel_obs.pop_front(); if (o !== k + 8) begin n_err++; $display("FAIL midsel_select: got cycle +%0d expected +8", o - k); end end
      n_cmp++;
      if (mr_obs.size() != 1) begin n_err++; $display("FAIL midsel_count: got %0d pulses expected 1", mr_obs.size()); end
      else begin o = mr_obs.pop_front(); if (o !== k + 7) begin n_err++; $display("FAIL midsel_rise: got cycle +%0d expected +7", o - k); end end
      n_cmp++;
      if (mf_obs.size() != 1) begin n_err++; $display("FAIL midsel_fall: got %0d falls expected 1", mf_obs.size()); end
      else begin o = mf_obs.pop_front(); if (o !== k + 10) begin n_err++; $display("FAIL midsel_fall: got cycle +%0d expected +10", o - k); end end
      sw_mode = 1'b1;
      tick(8);
   endtask

   task automatic test_reset_mid_pulse();
      btn_step = 1'b1;
      tick(8);
      n_cmp++; if (mpulse !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %b expected 1", mpulse); end
      rst = 1'b1;
      tick(1);
      n_cmp++; if (mpulse !== 1'b0) begin n_err++; $display("FAIL rstmid_mpulse: got %b expected 0", mpulse); end
      n_cmp++; if (apulse !== 1'b0) begin n_err++; $display("FAIL rstmid_apulse: got %b expected 0", apulse); end
      n_cmp++; if (select !== 1'b1) begin n_err++; $display("FAIL rstmid_select: got %b expected 1", select); end
      btn_step = 1'b0;
      tick(1);
      rst = 1'b0;
      mr_obs.delete();
      tick(14);
      n_cmp++; if (mr_obs.size() != 0) begin n_err++; $display("FAIL rstmid_after: got %0d pulses expected 0", mr_obs.size()); end
   endtask

   initial begin
      test_reset();
      test_div_load();
      test_hold(20);
      test_bounce();
      test_select();
      test_select_mid_pulse();
      test_hold(40);
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
